bram_pktbuf_ctrl: RTL and testbench

Frame-oriented store-and-forward buffer controller for the 4096x8 true-dual-port BRAM macro.
- Port A is the write side: a byte stream in, with commit/rollback per frame.
- Port B is the read side: complete frames out, with a valid/ready handshake.
- Sits between the MAC RX byte stream and the packet parser. Only error-free, fully received frames are ever presented downstream.

---
 rtl/bram_pktbuf_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_bram_pktbuf_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_pktbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bram_pktbuf_ctrl
// Purpose : Frame store-and-forward controller for a 4096x8 true-dual-port
//           BRAM. Port A takes a byte stream with per-frame commit/rollback.
//           Port B streams whole committed frames out through a 3-entry skid
//           FIFO that absorbs the 2-cycle OUTREG read latency.
// Option  : `define PKTBUF_DROP_STATS_EN adds drop_count / oflow_sticky.
// Rev     : 1.0  initial release
// ============================================================================
module bram_pktbuf_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int LEN_DEPTH = 8,
    parameter int MAX_FRAME = 1522
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    input  logic              s_error,
    output logic              s_ready,
    output logic [7:0]        m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [7:0]        bram_dia,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addrb,
    input  logic [7:0]        bram_dob,
    output logic [ADDR_W:0]   free_bytes,
    output logic [3:0]        frame_count
`ifdef PKTBUF_DROP_STATS_EN
    ,
    output logic [15:0]       drop_count,
    output logic              oflow_sticky
`endif
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int LEN_W = $clog2(MAX_FRAME + 1);
    localparam int LF_AW = $clog2(LEN_DEPTH);

    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] C_DEPTH   = PTR_W'(1 << ADDR_W);
    localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] C_LEN_MAX = LEN_W'(MAX_FRAME);
    localparam logic [LF_AW:0]   C_LF_ONE  = (LF_AW + 1)'(1);
    localparam logic [3:0]       C_FC_MAX  = 4'(LEN_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_t;

    // ---------------------------------------------------------------- state
    logic                  run_q,      run_d;
    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]      wr_cmt_q,   wr_cmt_d;
    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]      rd_done_q,  rd_done_d;
    logic [LEN_W-1:0]      frm_len_q,  frm_len_d;
    logic                  drop_q,     drop_d;
    logic                  in_frame_q, in_frame_d;
    logic [LEN_W-1:0]      lf_mem_q [LEN_DEPTH];
    logic [LEN_W-1:0]      lf_mem_d [LEN_DEPTH];
    logic [LF_AW:0]        lf_wp_q,    lf_wp_d;
    logic [LF_AW:0]        lf_rp_q,    lf_rp_d;
    rd_state_t             state_q,    state_d;
    logic [LEN_W-1:0]      rd_rem_q,   rd_rem_d;
    logic [1:0]            if_q,       if_d;
    logic [1:0]            tag_q,      tag_d;
    logic [7:0]            skid_data_q [3];
    logic [7:0]            skid_data_d [3];
    logic [2:0]            skid_last_q, skid_last_d;
    logic [1:0]            skid_wp_q,  skid_wp_d;
    logic [1:0]            skid_rp_q,  skid_rp_d;
    logic [1:0]            skid_cnt_q, skid_cnt_d;
    logic [3:0]            frame_cnt_q, frame_cnt_d;
`ifdef PKTBUF_DROP_STATS_EN
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  oflow_q,    oflow_d;
`endif

    // ------------------------------------------------------------ datapath
    logic [PTR_W-1:0]      w_used;
    logic                  w_free_zero;
    logic                  w_acc;
    logic                  w_drop_now;
    logic                  w_wr_en;
    logic                  w_commit;
    logic                  w_rollback;
    logic                  w_lf_empty;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_occ;
    logic                  w_m_hs;

    assign w_used      = wr_ptr_q - rd_done_q;
    assign w_free_zero = (w_used == C_DEPTH);
    // Back-pressure counts frames not yet fully delivered, which also bounds
    // the length FIFO; it only bites between frames.
    assign s_ready     = run_q & (in_frame_q | (frame_cnt_q != C_FC_MAX));
    assign w_acc       = s_valid & s_ready;
    assign w_drop_now  = drop_q | w_free_zero | (frm_len_q == C_LEN_MAX);
    assign w_wr_en     = w_acc & ~w_drop_now;
    assign w_commit    = w_acc & s_last & ~s_error & ~w_drop_now;
    assign w_rollback  = w_acc & s_last & (s_error | w_drop_now);
    assign w_lf_empty  = (lf_wp_q == lf_rp_q);
    assign w_occ       = 3'(if_q[0]) + 3'(if_q[1]) + 3'(skid_cnt_q);
    assign w_m_hs      = m_valid & m_ready;

    assign bram_wea    = w_wr_en;
    assign bram_addra  = wr_ptr_q[ADDR_W-1:0];
    assign bram_dia    = w_wr_en ? s_data : 8'h00;
    assign bram_addrb  = rd_ptr_q[ADDR_W-1:0];
    assign free_bytes  = C_DEPTH - w_used;
    assign frame_count = frame_cnt_q;
    assign m_valid     = (skid_cnt_q != 2'd0);
    assign m_data      = skid_data_q[skid_rp_q];
    assign m_last      = m_valid & skid_last_q[skid_rp_q];
`ifdef PKTBUF_DROP_STATS_EN
    assign drop_count   = drop_cnt_q;
    assign oflow_sticky = oflow_q;
`endif

    // Write side: tentative pointer, frame length, drop flag, commit/rollback.
    always_comb begin
        run_d      = 1'b1;
        wr_ptr_d   = wr_ptr_q;
        wr_cmt_d   = wr_cmt_q;
        frm_len_d  = frm_len_q;
        drop_d     = drop_q;
        in_frame_d = in_frame_q;
        if (w_acc) begin
            in_frame_d = ~s_last;
            if (s_last) begin
                frm_len_d = '0;
                drop_d    = 1'b0;
                if (w_commit) begin
                    wr_ptr_d = wr_ptr_q + C_PTR_ONE;
                    wr_cmt_d = wr_ptr_q + C_PTR_ONE;
                end else begin
                    wr_ptr_d = wr_cmt_q;
                end
            end else begin
                if (w_wr_en) begin
                    wr_ptr_d  = wr_ptr_q + C_PTR_ONE;
                    frm_len_d = frm_len_q + C_LEN_ONE;
                end
                if (w_drop_now) begin
                    drop_d = 1'b1;
                end
            end
        end
    end

    // Length FIFO: push on commit, pop when the read FSM starts a frame.
    always_comb begin
        lf_mem_d = lf_mem_q;
        lf_wp_d  = lf_wp_q;
        lf_rp_d  = lf_rp_q;
        if (w_commit) begin
            lf_mem_d[lf_wp_q[LF_AW-1:0]] = frm_len_q + C_LEN_ONE;
            lf_wp_d = lf_wp_q + C_LF_ONE;
        end
        if (w_pop) begin
            lf_rp_d = lf_rp_q + C_LF_ONE;
        end
    end

    // Read FSM: fetch a frame length, then issue reads while the skid has room.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        rd_rem_d = rd_rem_q;
        w_pop    = 1'b0;
        w_issue  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_lf_empty) begin
                    w_pop    = 1'b1;
                    rd_rem_d = lf_mem_q[lf_rp_q[LF_AW-1:0]];
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_occ < 3'd3) begin
                    w_issue  = 1'b1;
                    rd_ptr_d = rd_ptr_q + C_PTR_ONE;
                    rd_rem_d = rd_rem_q - C_LEN_ONE;
                    if (rd_rem_q == C_LEN_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read pipeline: track reads in flight and capture returning bytes.
    always_comb begin
        if_d        = {if_q[0], w_issue};
        tag_d       = {tag_q[0], w_issue & (rd_rem_q == C_LEN_ONE)};
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        skid_wp_d   = skid_wp_q;
        skid_rp_d   = skid_rp_q;
        skid_cnt_d  = skid_cnt_q;
        if (if_q[1]) begin
            skid_data_d[skid_wp_q] = bram_dob;
            skid_last_d[skid_wp_q] = tag_q[1];
            skid_wp_d = (skid_wp_q == 2'd2) ? 2'd0 : skid_wp_q + 2'd1;
        end
        if (w_m_hs) begin
            skid_rp_d = (skid_rp_q == 2'd2) ? 2'd0 : skid_rp_q + 2'd1;
        end
        if (if_q[1] && !w_m_hs) begin
            skid_cnt_d = skid_cnt_q + 2'd1;
        end else if (!if_q[1] && w_m_hs) begin
            skid_cnt_d = skid_cnt_q - 2'd1;
        end
    end

    // Space release, frame occupancy and optional drop statistics.
    always_comb begin
        rd_done_d   = rd_done_q;
        frame_cnt_d = frame_cnt_q;
        if (w_m_hs) begin
            rd_done_d = rd_done_q + C_PTR_ONE;
        end
        if (w_commit && !(w_m_hs && m_last)) begin
            frame_cnt_d = frame_cnt_q + 4'd1;
        end else if (!w_commit && w_m_hs && m_last) begin
            frame_cnt_d = frame_cnt_q - 4'd1;
        end
`ifdef PKTBUF_DROP_STATS_EN
        drop_cnt_d = drop_cnt_q;
        oflow_d    = oflow_q;
        if (w_rollback && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (w_acc && w_free_zero) begin
            oflow_d = 1'b1;
        end
`endif
    end

    // State registers; reset discards all frames and reads in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            wr_ptr_q    <= '0;
            wr_cmt_q    <= '0;
            rd_ptr_q    <= '0;
            rd_done_q   <= '0;
            frm_len_q   <= '0;
            drop_q      <= 1'b0;
            in_frame_q  <= 1'b0;
            lf_mem_q    <= '{default: '0};
            lf_wp_q     <= '0;
            lf_rp_q     <= '0;
            state_q     <= ST_IDLE;
            rd_rem_q    <= '0;
            if_q        <= '0;
            tag_q       <= '0;
            skid_data_q <= '{default: '0};
            skid_last_q <= '0;
            skid_wp_q   <= '0;
            skid_rp_q   <= '0;
            skid_cnt_q  <= '0;
            frame_cnt_q <= '0;
`ifdef PKTBUF_DROP_STATS_EN
            drop_cnt_q  <= '0;
            oflow_q     <= 1'b0;
`endif
        end else begin
            run_q       <= run_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_cmt_q    <= wr_cmt_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_done_q   <= rd_done_d;
            frm_len_q   <= frm_len_d;
            drop_q      <= drop_d;
            in_frame_q  <= in_frame_d;
            lf_mem_q    <= lf_mem_d;
            lf_wp_q     <= lf_wp_d;
            lf_rp_q     <= lf_rp_d;
            state_q     <= state_d;
            rd_rem_q    <= rd_rem_d;
            if_q        <= if_d;
            tag_q       <= tag_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            skid_wp_q   <= skid_wp_d;
            skid_rp_q   <= skid_rp_d;
            skid_cnt_q  <= skid_cnt_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef PKTBUF_DROP_STATS_EN
            drop_cnt_q  <= drop_cnt_d;
            oflow_q     <= oflow_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_pktbuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_bram_pktbuf_ctrl
// Purpose : Directed self-checking bench for bram_pktbuf_ctrl with a
//           behavioural 4096x8 OUTREG BRAM and a byte scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_bram_pktbuf_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_error, s_ready;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_ready;
    logic [11:0] bram_addra, bram_addrb;
    logic [7:0]  bram_dia, bram_dob;
    logic        bram_wea;
    logic [12:0] free_bytes;
    logic [3:0]  frame_count;
`ifdef PKTBUF_DROP_STATS_EN
    logic [15:0] drop_count;
    logic        oflow_sticky;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          m_mode = 0;       // 0: m_ready low, 1: high, 2: random
    logic [8:0]  exp_q [$];
    logic [7:0]  mem [4096];
    logic [11:0] addr_r;

    always #5 clk = ~clk;

    bram_pktbuf_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_error     (s_error),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .bram_addra  (bram_addra),
        .bram_dia    (bram_dia),
        .bram_wea    (bram_wea),
        .bram_addrb  (bram_addrb),
        .bram_dob    (bram_dob),
        .free_bytes  (free_bytes),
        .frame_count (frame_count)
`ifdef PKTBUF_DROP_STATS_EN
        ,
        .drop_count  (drop_count),
        .oflow_sticky(oflow_sticky)
`endif
    );

    // BRAM model: synchronous write on A, address + output register on B
    always @(posedge clk) begin
        if (bram_wea) mem[bram_addra] <= bram_dia;
        addr_r   <= bram_addrb;
        bram_dob <= mem[addr_r];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // m_ready driver
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (m_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output scoreboard: every handshake must match the next expected byte
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && m_valid && m_ready) begin
            e = (exp_q.size() != 0) ? {23'd0, exp_q.pop_front()} : 32'h200;
            chk("m_byte", {23'd0, m_last, m_data}, e);
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_accept();
        int  t = 0;
        bit  a;
        do begin
            @(negedge clk); a = s_ready;
            @(posedge clk); #1; t++;
        end while (!a && t < 2000);
        if (!a) chk("s_ready_timeout", 32'(a), 32'd1);
    endtask

    task automatic send_frame(input int len, input int seed, input bit err, input bit ok);
        for (int i = 0; i < len; i++) begin
            s_data  = 8'(seed + i);
            s_valid = 1'b1;
            s_last  = (i == len - 1);
            s_error = err && (i == len - 1);
            if (ok) exp_q.push_back({s_last, s_data});
            wait_accept();
        end
        s_valid = 1'b0; s_last = 1'b0; s_error = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while ((frame_count != 4'd0 || m_valid) && t < 30000) begin step(1); t++; end
        chk({tag, "_drain"}, {27'd0, m_valid, frame_count}, 32'd0);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        step(2);
        chk({tag, "_free"}, 32'(free_bytes), 32'd4096);
    endtask

    task automatic wait_free(input int need);
        int t = 0;
        while (int'(free_bytes) < need && t < 30000) begin step(1); t++; end
        chk("free_wait", 32'(int'(free_bytes) >= need), 32'd1);
    endtask

    initial begin
        int lens [8] = '{300, 1, 777, 1522, 1523, 45, 1200, 2};
        rst_n = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; s_error = 1'b0;
        step(3);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_wea",     32'(bram_wea), 32'd0);
        chk("rst_free",    32'(free_bytes), 32'd4096);
        chk("rst_fcnt",    32'(frame_count), 32'd0);
        rst_n = 1'b1;
        step(2);

        // 64-byte frame, latency from commit edge to first m_valid
        m_mode = 1;
        send_frame(64, 0, 1'b0, 1'b1);
        chk("t1_fcnt", 32'(frame_count), 32'd1);
        chk("t1_free", 32'(free_bytes), 32'd4032);
        step(3);
        chk("t1_lat3", 32'(m_valid), 32'd0);
        step(1);
        chk("t1_lat4", 32'(m_valid), 32'd1);
        chk("t1_first", {23'd0, m_last, m_data}, 32'h000);
        wait_drain("t1");

        // errored frame rolled back, good frame follows
        send_frame(60, 8'h80, 1'b1, 1'b0);
        step(1);
        chk("t2_free_rb", 32'(free_bytes), 32'd4096);
        chk("t2_fcnt",    32'(frame_count), 32'd0);
        send_frame(10, 8'hA0, 1'b0, 1'b1);
        wait_drain("t2");
`ifdef PKTBUF_DROP_STATS_EN
        chk("t2_drops", 32'(drop_count), 32'd1);
        chk("t2_oflow", 32'(oflow_sticky), 32'd0);
`endif

        // fill to 96 free, then a 200-byte frame overflows
        m_mode = 0;
        for (int k = 0; k < 4; k++) send_frame(1000, k * 7, 1'b0, 1'b1);
        step(1);
        chk("t3_free", 32'(free_bytes), 32'd96);
        chk("t3_fcnt", 32'(frame_count), 32'd4);
        send_frame(200, 8'h55, 1'b0, 1'b0);
        step(1);
        chk("t3_free_rb", 32'(free_bytes), 32'd96);
        chk("t3_fcnt_rb", 32'(frame_count), 32'd4);
`ifdef PKTBUF_DROP_STATS_EN
        chk("t3_drops", 32'(drop_count), 32'd2);
        chk("t3_oflow", 32'(oflow_sticky), 32'd1);
`endif
        m_mode = 1;
        wait_drain("t3");

        // exact fill to zero free, then a 1-byte frame must drop
        m_mode = 0;
        send_frame(1500, 8'h11, 1'b0, 1'b1);
        send_frame(1500, 8'h22, 1'b0, 1'b1);
        send_frame(1096, 8'h33, 1'b0, 1'b1);
        step(1);
        chk("t3b_free0", 32'(free_bytes), 32'd0);
        chk("t3b_fcnt",  32'(frame_count), 32'd3);
        send_frame(1, 8'h44, 1'b0, 1'b0);
        step(1);
        chk("t3b_free0_rb", 32'(free_bytes), 32'd0);
        chk("t3b_fcnt_rb",  32'(frame_count), 32'd3);
        m_mode = 1;
        wait_drain("t3b");

        // wrap-straddling frames under random m_ready, one oversize frame
        m_mode = 2;
        foreach (lens[i]) begin
            wait_free((lens[i] > 1522) ? 1522 : lens[i]);
            send_frame(lens[i], 8'h60 + i, 1'b0, lens[i] <= 1522);
        end
        wait_drain("t4");
`ifdef PKTBUF_DROP_STATS_EN
        chk("t4_drops", 32'(drop_count), 32'd4);
`endif

        // nine 1-byte frames with the read side stalled
        m_mode = 0;
        for (int k = 0; k < 8; k++) send_frame(1, 8'hC0 + k, 1'b0, 1'b1);
        chk("t5_s_ready", 32'(s_ready), 32'd0);
        chk("t5_fcnt",    32'(frame_count), 32'd8);
        step(5);
        chk("t5_s_ready_hold", 32'(s_ready), 32'd0);
        chk("t5_m_last",  {30'd0, m_valid, m_last}, 32'd3);
        m_mode = 1;
        send_frame(1, 8'hC8, 1'b0, 1'b1);
        wait_drain("t5");

        // reset with a frame waiting on the read side and one half-written
        m_mode = 0;
        send_frame(20, 8'h10, 1'b0, 1'b1);
        step(8);
        chk("t6_m_valid_pre", 32'(m_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            s_data = 8'(8'hF0 + k); s_valid = 1'b1; s_last = 1'b0;
            wait_accept();
        end
        rst_n = 1'b0;
        #1;
        chk("t6_m_valid", 32'(m_valid), 32'd0);
        chk("t6_free",    32'(free_bytes), 32'd4096);
        chk("t6_fcnt",    32'(frame_count), 32'd0);
        chk("t6_s_ready", 32'(s_ready), 32'd0);
`ifdef PKTBUF_DROP_STATS_EN
        chk("t6_drops",   32'(drop_count), 32'd0);
`endif
        exp_q.delete();
        s_valid = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        send_frame(5, 8'hE0, 1'b0, 1'b1);
        m_mode = 1;
        wait_drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
